// File: rtl/sr_cmd_pkg.sv
// Shared types and sizing helpers for the SR command front end.
// Holds the command FSM state encoding and the counter-width helper.
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    CLR_P = 2'd2,
    GUARD = 2'd3
  } state_t;

  // Bits needed for a counter that must hold values 0..max(a,b).
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer.
// db follows the synchronised input once it has differed from db for DEB_CYCLES edges.
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam int             CW       = cnt_width(DEB_CYCLES, DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // NOTE: non-blocking assignments so every flop samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sr_cmd_debounce.sv
// Debounced set/clear push-buttons turned into clean, non-overlapping s/r pulses
// for the SR flip-flop; clear always wins over a concurrent or pending set.
module sr_cmd_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GUARD_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic set_raw,
  input  logic clr_raw,
  output logic s,
  output logic r,
  output logic set_db,
  output logic clr_db,
  output logic busy,
  output logic conflict
);

  localparam int            TW         = cnt_width(PULSE_CYCLES, GUARD_CYCLES);
  localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GUARD_LOAD = TW'(GUARD_CYCLES - 1);

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_next;
  logic          set_db_q;
  logic          clr_db_q;
  logic          set_rise;
  logic          clr_rise;
  logic          set_pend;
  logic          clr_pend;
  logic          set_pend_next;
  logic          clr_pend_next;
  logic          s_next;
  logic          r_next;
  logic          busy_next;
  logic          conflict_next;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (set_raw),
    .db    (set_db)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_deb (
    .clk   (clk),
    .reset (reset),
    .raw   (clr_raw),
    .db    (clr_db)
  );

  assign set_rise = set_db & ~set_db_q;
  assign clr_rise = clr_db & ~clr_db_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tmr      <= '0;
      set_db_q <= 1'b0;
      clr_db_q <= 1'b0;
      set_pend <= 1'b0;
      clr_pend <= 1'b0;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= next_state;
      tmr      <= tmr_next;
      set_db_q <= set_db;
      clr_db_q <= clr_db;
      set_pend <= set_pend_next;
      clr_pend <= clr_pend_next;
      s        <= s_next;
      r        <= r_next;
      busy     <= busy_next;
      conflict <= conflict_next;
    end
  end

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    tmr_next   = tmr;
    case (state)
      IDLE: begin
        if (clr_pend || clr_rise) begin
          next_state = CLR_P;
          tmr_next   = PULSE_LOAD;
        end else if (set_pend || set_rise) begin
          next_state = SET_P;
          tmr_next   = PULSE_LOAD;
        end
      end
      SET_P, CLR_P: begin
        if (tmr == '0) begin
          next_state = GUARD;
          tmr_next   = GUARD_LOAD;
        end else begin
          tmr_next = tmr - TW'(1);
        end
      end
      GUARD: begin
        if (tmr == '0) begin
          next_state = IDLE;
        end else begin
          tmr_next = tmr - TW'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // A clear rise discards any set that is arriving or already waiting.
  always_comb begin
    conflict_next = clr_rise & (set_rise | set_pend);
    clr_pend_next = clr_pend | clr_rise;
    set_pend_next = set_pend | set_rise;
    if (state == IDLE && next_state == CLR_P) clr_pend_next = 1'b0;
    if (clr_rise || (state == IDLE && next_state == SET_P)) set_pend_next = 1'b0;
    s_next    = (next_state == SET_P);
    r_next    = (next_state == CLR_P);
    busy_next = (next_state != IDLE);
  end

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Self-checking bench for sr_cmd_debounce: directed scenarios plus random presses,
// all compared against a timeline-based reference model.
module tb_sr_cmd_debounce;

  localparam int DEB   = 4;
  localparam int PULSE = 2;
  localparam int GUARD = 1;
  localparam int MASK  = 4095;

  logic clk;
  logic reset;
  logic set_raw;
  logic clr_raw;
  logic s;
  logic r;
  logic set_db;
  logic clr_db;
  logic busy;
  logic conflict;

  int tests = 0;
  int fails = 0;

  sr_cmd_debounce #(
    .DEB_CYCLES   (DEB),
    .PULSE_CYCLES (PULSE),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .set_raw  (set_raw),
    .clr_raw  (clr_raw),
    .s        (s),
    .r        (r),
    .set_db   (set_db),
    .clr_db   (clr_db),
    .busy     (busy),
    .conflict (conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  wire [5:0] obs = {s, r, set_db, clr_db, busy, conflict};

  // Reference model: raw samples per edge, debounce judged over a window of
  // synchronised samples, pulses scheduled as time intervals.
  bit        raw_at  [2][MASK+1];
  bit        db_hist [2][MASK+1];
  bit        db_m    [2];
  int        e       = 0;
  int        rst_e   = 0;
  int        ps      = -1000;
  int        next_ok = 0;
  bit        kind_clr;
  bit        set_pend_m;
  bit        clr_pend_m;
  logic [5:0] exp_vec = '0;

  function automatic bit sync2_at(input int ch, input int k);
    if (k - 2 > rst_e) return raw_at[ch][(k - 2) & MASK];
    return 1'b0;
  endfunction

  initial begin
    bit sr, cr, conf, set_eff, clr_eff, stable, in_p, in_b;
    forever begin
      @(posedge clk);
      e = e + 1;
      raw_at[0][e & MASK] = set_raw;
      raw_at[1][e & MASK] = clr_raw;
      if (reset) begin
        rst_e      = e;
        db_m[0]    = 1'b0;
        db_m[1]    = 1'b0;
        db_hist[0][e & MASK] = 1'b0;
        db_hist[1][e & MASK] = 1'b0;
        set_pend_m = 1'b0;
        clr_pend_m = 1'b0;
        ps         = -1000;
        next_ok    = e + 1;
        exp_vec    = '0;
      end else begin
        sr = db_hist[0][(e - 1) & MASK] & ~db_hist[0][(e - 2) & MASK];
        cr = db_hist[1][(e - 1) & MASK] & ~db_hist[1][(e - 2) & MASK];
        conf    = cr & (sr | set_pend_m);
        set_eff = cr ? 1'b0 : (set_pend_m | sr);
        clr_eff = clr_pend_m | cr;
        if (e >= next_ok) begin
          if (clr_eff) begin
            kind_clr = 1'b1; ps = e; clr_eff = 1'b0; next_ok = e + PULSE + GUARD + 1;
          end else if (set_eff) begin
            kind_clr = 1'b0; ps = e; set_eff = 1'b0; next_ok = e + PULSE + GUARD + 1;
          end
        end
        set_pend_m = set_eff;
        clr_pend_m = clr_eff;
        for (int ch = 0; ch < 2; ch++) begin
          stable = (e - DEB + 1 > rst_e);
          for (int k = e - DEB + 1; k <= e; k++)
            if (sync2_at(ch, k) == db_m[ch]) stable = 1'b0;
          if (stable) db_m[ch] = ~db_m[ch];
          db_hist[ch][e & MASK] = db_m[ch];
        end
        in_p = (e >= ps) && (e < ps + PULSE);
        in_b = (e >= ps) && (e < ps + PULSE + GUARD);
        exp_vec = {in_p & ~kind_clr, in_p & kind_clr, db_m[0], db_m[1], in_b, conf};
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    set_raw = 1'b0;
    clr_raw = 1'b0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    tests++;
    if (obs !== 6'b0) begin
      fails++;
      $display("FAIL reset_state: got %b want 000000", obs);
    end
    reset = 1'b0;
    tick();
    tests++;
    if (obs !== exp_vec) begin
      fails++;
      $display("FAIL reset_release: got %b want %b", obs, exp_vec);
    end
  endtask

  task automatic test_set_press();
    set_raw = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      tick();
      tests++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL set_press_model edge %0d: got %b want %b", n, obs, exp_vec);
      end
      tests++;
      if ({set_db, s, busy, r} !== {(n >= 6), (n == 7 || n == 8), (n >= 7 && n <= 9), 1'b0}) begin
        fails++;
        $display("FAIL set_press_timing edge %0d: got db/s/busy/r=%b%b%b%b", n, set_db, s, busy, r);
      end
    end
    settle(25);
  endtask

  task automatic test_glitch();
    set_raw = 1'b1;
    for (int n = 1; n <= 23; n++) begin
      if (n == 4) set_raw = 1'b0;
      tick();
      tests++;
      if ({set_db, s, busy} !== 3'b000 || obs !== exp_vec) begin
        fails++;
        $display("FAIL glitch edge %0d: got %b want %b", n, obs, exp_vec);
      end
    end
    settle(5);
  endtask

  task automatic test_simultaneous();
    int conf_cnt = 0;
    set_raw = 1'b1;
    clr_raw = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      tick();
      conf_cnt += int'(conflict);
      tests++;
      if (obs !== exp_vec || r !== (n == 7 || n == 8) || s !== 1'b0) begin
        fails++;
        $display("FAIL simultaneous edge %0d: got %b want %b", n, obs, exp_vec);
      end
    end
    tests++;
    if (conf_cnt != 1) begin
      fails++;
      $display("FAIL simultaneous_conflict_count: got %0d want 1", conf_cnt);
    end
    settle(25);
  endtask

  task automatic test_queued();
    int s_cnt = 0, r_cnt = 0, last_s = -1, first_r = -1;
    set_raw = 1'b1;
    tick();
    clr_raw = 1'b1;
    for (int n = 2; n <= 26; n++) begin
      tick();
      if (s) begin s_cnt++; last_s = n; end
      if (r) begin r_cnt++; if (first_r < 0) first_r = n; end
      tests++;
      if (obs !== exp_vec || (s && r)) begin
        fails++;
        $display("FAIL queued edge %0d: got %b want %b", n, obs, exp_vec);
      end
    end
    tests++;
    if (s_cnt != PULSE || r_cnt != PULSE || first_r != last_s + GUARD + 2) begin
      fails++;
      $display("FAIL queued_sequence: got s=%0d r=%0d last_s=%0d first_r=%0d want %0d/%0d gap %0d",
               s_cnt, r_cnt, last_s, first_r, PULSE, PULSE, GUARD + 2);
    end
    settle(25);
  endtask

  task automatic test_reset_mid_pulse();
    int waited = 0;
    set_raw = 1'b1;
    while (s !== 1'b1 && waited < 12) begin
      tick();
      waited++;
    end
    tests++;
    if (s !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pulse_start: got s=%b want 1 within 12 cycles", s);
    end
    reset   = 1'b1;
    set_raw = 1'b0;
    tick();
    tests++;
    if (obs !== 6'b0) begin
      fails++;
      $display("FAIL reset_mid_pulse: got %b want 000000", obs);
    end
    reset = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      tests++;
      if ({s, r, busy} !== 3'b000 || obs !== exp_vec) begin
        fails++;
        $display("FAIL reset_mid_pulse_after edge %0d: got %b want %b", n, obs, exp_vec);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, width = 0;
    logic prev_s = 1'b0;
    for (int n = 0; n < 62; n++) begin
      set_raw = ((n % 30) < 10) && (n < 60);
      tick();
      tests++;
      if (obs !== exp_vec) begin
        fails++;
        $display("FAIL back_to_back_model cycle %0d: got %b want %b", n, obs, exp_vec);
      end
      if (s && !prev_s) begin pulses++; width = 1; end
      else if (s) width++;
      else if (prev_s) begin
        tests++;
        if (width != PULSE || busy !== 1'b1) begin
          fails++;
          $display("FAIL back_to_back_pulse: got width %0d guard busy %b want %0d/1", width, busy, PULSE);
        end
      end
      prev_s = s;
    end
    tests++;
    if (pulses != 2) begin
      fails++;
      $display("FAIL back_to_back_count: got %0d want 2", pulses);
    end
    settle(20);
  endtask

  task automatic test_random();
    int set_hold = 0, clr_hold = 0;
    for (int n = 0; n < 900; n++) begin
      if (set_hold == 0) begin
        set_raw  = 1'($urandom_range(0, 1));
        set_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
      end
      if (clr_hold == 0) begin
        clr_raw  = ($urandom_range(0, 2) == 0);
        clr_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
      end
      set_hold--;
      clr_hold--;
      tick();
      tests++;
      if (obs !== exp_vec || (s && r)) begin
        fails++;
        $display("FAIL random cycle %0d: got %b want %b", n, obs, exp_vec);
      end
    end
    settle(10);
  endtask

  initial begin
    reset   = 1'b1;
    set_raw = 1'b0;
    clr_raw = 1'b0;
    test_reset();
    settle(10);
    test_set_press();
    test_glitch();
    test_simultaneous();
    test_queued();
    test_reset_mid_pulse();
    settle(10);
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_cmd_debounce.md
Name: sr_cmd_debounce

Overview:
- Upstream command stage for the team's SR flip-flop.
- Takes two raw, asynchronous push-button lines (set request, clear request), synchronises and debounces each, and converts debounced rising edges into clean, fixed-width s/r pulses.
- Those pulses drive the flip-flop's s and r inputs directly.
- Guarantees the flip-flop never sees s=r=1. Conflicting requests are resolved here, with clear taking priority.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles required before a debounced level changes (must be >=1).
- PULSE_CYCLES, 2: width in clk cycles of each s or r pulse (must be >=1).
- GUARD_CYCLES, 1: cycles with s=r=0 after every pulse before the next pulse may start (must be >=1).

Ports:
- clk  input  1  single clock; all state updates on rising edge, so s/r are stable half a cycle before the flip-flop's falling-edge sample.
- reset  input  1  synchronous, active-high reset.
- set_raw  input  1  raw asynchronous set request.
- clr_raw  input  1  raw asynchronous clear request.
- s  output  1  set pulse to the flip-flop.
- r  output  1  clear pulse to the flip-flop.
- set_db  output  1  debounced set level.
- clr_db  output  1  debounced clear level.
- busy  output  1  high while in SET_P, CLR_P or GUARD.
- conflict  output  1  one-cycle pulse when a set request is discarded because of a simultaneous clear.

Behaviour:
- Reset:
  - Evaluated on the clk rising edge only; reset=1 overrides everything.
  - s, r, set_db, clr_db, busy and conflict are all 0.
  - Synchroniser flops, debounce counters, pending flags and the pulse/guard counter are cleared.
  - FSM goes to IDLE.
  - Reset asserted mid-pulse ends s/r on that same edge; no pulse resumes afterwards.
- Synchroniser: two flops per input. The synchronised value (sync2) is valid after 2 edges.
- Debounce, per channel:
  - Counter width is $clog2(DEB_CYCLES+1).
  - If sync2 == db, the counter clears.
  - Otherwise the counter increments. On the edge where it would reach DEB_CYCLES, db toggles and the counter clears.
  - A raw glitch shorter than DEB_CYCLES cycles (after synchronisation) never changes db.
- Edge detect: rise = db & ~db_q, where db_q is db delayed by one cycle. Only rising edges generate commands; falling edges are ignored.
- Pending flags:
  - set_pend and clr_pend are set by their respective rise events.
  - Each holds at most one request. A repeated rise while that flag is already set is absorbed.
  - A flag is cleared when the FSM enters its pulse state.
- FSM states: IDLE, SET_P, CLR_P, GUARD.
  - IDLE: if clr_pend or a clear rise this cycle, go to CLR_P. Else if set_pend or a set rise this cycle, go to SET_P. Else stay.
  - SET_P: s=1, r=0 for exactly PULSE_CYCLES cycles, then go to GUARD.
  - CLR_P: r=1, s=0 for exactly PULSE_CYCLES cycles, then go to GUARD.
  - GUARD: s=r=0 for exactly GUARD_CYCLES cycles, then go to IDLE. Pending requests are serviced from IDLE the following cycle.
  - A shared down-counter of width $clog2(max(PULSE_CYCLES,GUARD_CYCLES)+1) times the pulse and guard states.
- Conflict handling:
  - Set and clear rises in the same cycle: set is discarded and conflict pulses for 1 cycle.
  - A set already pending when a clear rise arrives is also discarded, with a conflict pulse.
  - Rationale: clear-wins is the safe state.
- Requests arriving during pulse or guard: the request is latched as pending (subject to the conflict rule above) and never dropped silently.
- Outputs: s and r are registered, never both 1, and never glitch.
- Latency: a raw rise held stable gives db high after edge 2+DEB_CYCLES and s/r high after edge 3+DEB_CYCLES.

Decomposition:
- Package sr_cmd_pkg: state enum (IDLE, SET_P, CLR_P, GUARD) and a localparam helper for counter widths.
- One natural sub-module, sr_debounce (2-flop sync plus stable-count debouncer, parameter DEB_CYCLES, ports clk, reset, raw, db), instantiated twice.
- FSM, pending flags and timing counter stay in the top module.

Test Plan (defaults DEB_CYCLES=4, PULSE_CYCLES=2, GUARD_CYCLES=1; edges counted from the raw change):
- Set press: set_raw 0->1 and held -> set_db=1 after edge 6, s=1 after edges 7-8, s=0 after edge 9, busy=0 after edge 10, r stays 0 throughout.
- Glitch rejection: set_raw high for 3 cycles then low -> set_db, s and busy stay 0 for 20 cycles.
- Simultaneous press: set_raw and clr_raw rise on the same cycle -> r=1 for 2 cycles starting after edge 7, conflict=1 for exactly 1 cycle, s never asserts.
- Queued request: clr_raw rises while s is high -> s completes 2 cycles, 1 guard cycle with s=r=0, then r=1 for 2 cycles; s and r never both 1.
- Reset mid-pulse: reset=1 for 1 edge while s=1 -> s, busy, set_db and clr_db are 0 after that edge, FSM in IDLE, no further pulse while inputs stay 0.
- Back-to-back sets: two clean set presses 30 cycles apart -> two separate 2-cycle s pulses, each followed by a guard cycle.
